// File: rtl/main_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : main_mem_responder_pkg
//  Purpose  : Shared definitions for the main-memory responder: FSM state
//             type and encodings plus fixed address-format constants.
//  Revision : 1.0  initial release
// ============================================================================
package main_mem_responder_pkg;

    // Responder FSM state, kept as plain localparam encodings
    typedef logic [2:0] mem_state_t;

    localparam mem_state_t c_IDLE    = 3'd0;
    localparam mem_state_t c_RD_WAIT = 3'd1;
    localparam mem_state_t c_RD_BEAT = 3'd2;
    localparam mem_state_t c_WR_BEAT = 3'd3;
    localparam mem_state_t c_WR_DONE = 3'd4;

    // Byte-offset bits inside a word; addresses are word aligned internally
    localparam int c_BYTE_OFS_BITS = 2;

endpackage : main_mem_responder_pkg
`default_nettype wire

// File: rtl/main_mem_array.sv
`default_nettype none
// ============================================================================
//  Module   : main_mem_array
//  Purpose  : Word-addressed storage for the main-memory responder.
//             Synchronous write, combinational (asynchronous) read, single
//             shared address port. Contents are never reset.
//  Ports    : i_clk    clock
//             i_we     write enable (write happens on rising edge)
//             i_addr   word address for both read and write
//             i_wdata  write data
//             o_rdata  read data at i_addr (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module main_mem_array #(
    parameter int ADDR_BITS  = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_BITS-1:0]  i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_BITS)-1];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule : main_mem_array
`default_nettype wire

// File: rtl/main_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : main_mem_responder
//  Purpose  : Main-memory end of the cache<->memory link. Accepts single-word
//             or full-line read/write requests on a valid/ready handshake,
//             returns read beats after a fixed access latency and consumes
//             write beats one per cycle (gaps allowed).
//  Ports    : clk_i, rst_i (async, active-high)
//             req_valid_i/req_ready_o/req_write_i/req_burst_i/req_addr_i
//                          request handshake and attributes
//             wdata_valid_i/wdata_ready_o/wdata_i   write beat stream
//             rdata_valid_o/rdata_o/rdata_last_o    read beat stream
//             wr_done_o    one-cycle pulse after the last write beat
//             busy_o       responder not idle
//  Revision : 1.0  initial release
// ============================================================================
module main_mem_responder
    import main_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_ADDR_BITS = 17,
    parameter int LINE_WORDS    = 4,
    parameter int LATENCY       = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic                  req_burst_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  wdata_valid_i,
    output logic                  wdata_ready_o,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rdata_valid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rdata_last_o,
    output logic                  wr_done_o,
    output logic                  busy_o
);

    localparam int c_BEAT_W    = $clog2(LINE_WORDS);
    localparam int c_LAT_W     = $clog2(LATENCY + 1);
    localparam int c_WORD_BITS = MEM_ADDR_BITS - c_BYTE_OFS_BITS;
    localparam int c_LINE_BITS = c_WORD_BITS - c_BEAT_W;

    // RD_WAIT lasts LATENCY-1 cycles: the counter runs 0..LATENCY-2.
    // Unreachable when LATENCY==1, clamped so the constant stays legal.
    localparam logic [c_LAT_W-1:0] c_LAT_END =
        c_LAT_W'((LATENCY > 1) ? (LATENCY - 2) : 0);

    mem_state_t              r_state;
    logic [c_LAT_W-1:0]      r_lat_cnt;
    logic [c_BEAT_W-1:0]     r_idx;
    logic                    r_burst;
    logic [c_LINE_BITS-1:0]  r_line;

    logic                    w_last;
    logic                    w_we;
    logic [c_WORD_BITS-1:0]  w_word_addr;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic                    w_unused;

    // Upper address bits alias and the byte offset is dropped
    assign w_unused = ^{req_addr_i[ADDR_WIDTH-1:MEM_ADDR_BITS],
                        req_addr_i[c_BYTE_OFS_BITS-1:0]};

    // A single-beat transfer is always its own last beat; a burst ends when
    // the index reaches the top of the line (bursts always start at index 0).
    assign w_last      = !r_burst || (r_idx == {c_BEAT_W{1'b1}});
    assign w_we        = (r_state == c_WR_BEAT) && wdata_valid_i;
    assign w_word_addr = {r_line, r_idx};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= c_IDLE;
            r_lat_cnt <= '0;
            r_idx     <= '0;
            r_burst   <= 1'b0;
            r_line    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid_i) begin
                        r_burst   <= req_burst_i;
                        r_line    <= req_addr_i[MEM_ADDR_BITS-1 -: c_LINE_BITS];
                        // Bursts are line aligned; a single word keeps its
                        // position inside the line.
                        r_idx     <= req_burst_i ? '0
                                     : req_addr_i[c_BYTE_OFS_BITS +: c_BEAT_W];
                        r_lat_cnt <= '0;
                        if (req_write_i) begin
                            r_state <= c_WR_BEAT;
                        end else if (LATENCY == 1) begin
                            r_state <= c_RD_BEAT;
                        end else begin
                            r_state <= c_RD_WAIT;
                        end
                    end
                end
                c_RD_WAIT: begin
                    if (r_lat_cnt == c_LAT_END) begin
                        r_lat_cnt <= '0;
                        r_state   <= c_RD_BEAT;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + c_LAT_W'(1);
                    end
                end
                c_RD_BEAT: begin
                    r_idx <= r_idx + c_BEAT_W'(1);
                    if (w_last) begin
                        r_state <= c_IDLE;
                    end
                end
                c_WR_BEAT: begin
                    if (wdata_valid_i) begin
                        r_idx <= r_idx + c_BEAT_W'(1);
                        if (w_last) begin
                            r_state <= c_WR_DONE;
                        end
                    end
                end
                c_WR_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    main_mem_array #(
        .ADDR_BITS  (c_WORD_BITS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .i_clk   (clk_i),
        .i_we    (w_we),
        .i_addr  (w_word_addr),
        .i_wdata (wdata_i),
        .o_rdata (w_rdata)
    );

    // Outputs decode straight from state so an async reset clears them
    // immediately, without waiting for a clock edge.
    assign req_ready_o   = (r_state == c_IDLE);
    assign busy_o        = (r_state != c_IDLE);
    assign wdata_ready_o = (r_state == c_WR_BEAT);
    assign wr_done_o     = (r_state == c_WR_DONE);
    assign rdata_valid_o = (r_state == c_RD_BEAT);
    assign rdata_last_o  = rdata_valid_o && w_last;
    assign rdata_o       = rdata_valid_o ? w_rdata : '0;

endmodule : main_mem_responder
`default_nettype wire

// File: tb/tb_main_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_main_mem_responder
//  Purpose  : Self-checking bench for main_mem_responder: table of directed
//             transactions, hand-written reset/handshake sequences, random
//             traffic against a word-level memory model, and a LATENCY=1 build.
//  Revision : 1.0  initial release
// ============================================================================
module tb_main_mem_responder;

    localparam int LAT   = 3;
    localparam int LW    = 4;
    localparam int WMASK = (1 << 15) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    // DUT 0 (LATENCY=3)
    logic        req_valid, req_write, req_burst;
    logic [31:0] req_addr;
    logic        wdata_valid;
    logic [31:0] wdata;
    logic        req_ready, wdata_ready, rdata_valid, rdata_last, wr_done, busy;
    logic [31:0] rdata;
    // DUT 1 (LATENCY=1)
    logic        req_valid1, req_write1, req_burst1;
    logic [31:0] req_addr1;
    logic        wdata_valid1;
    logic [31:0] wdata1;
    logic        req_ready1, wdata_ready1, rdata_valid1, rdata_last1, wr_done1, busy1;
    logic [31:0] rdata1;

    main_mem_responder #(.LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_burst_i(req_burst), .req_addr_i(req_addr),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
        .rdata_valid_o(rdata_valid), .rdata_o(rdata), .rdata_last_o(rdata_last),
        .wr_done_o(wr_done), .busy_o(busy)
    );

    main_mem_responder #(.LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid1), .req_ready_o(req_ready1),
        .req_write_i(req_write1), .req_burst_i(req_burst1), .req_addr_i(req_addr1),
        .wdata_valid_i(wdata_valid1), .wdata_ready_o(wdata_ready1), .wdata_i(wdata1),
        .rdata_valid_o(rdata_valid1), .rdata_o(rdata1), .rdata_last_o(rdata_last1),
        .wr_done_o(wr_done1), .busy_o(busy1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: flat word memory ----------------
    logic [31:0] model [int];

    function automatic int word_of(input logic [31:0] a, input bit b, input int i);
        int w;
        w = int'((a >> 2) & 32'(WMASK));
        return b ? ((w & ~(LW - 1)) + i) : w;
    endfunction

    task automatic model_write(input logic [31:0] a, input bit b,
                               input logic [3:0][31:0] d, input int n);
        for (int i = 0; i < n; i++) model[word_of(a, b, i)] = d[i];
    endtask

    task automatic model_read(input logic [31:0] a, input bit b, input int n,
                              output logic [3:0][31:0] d, output logic [3:0] known);
        d = '0;
        known = '0;
        for (int i = 0; i < n; i++) begin
            if (model.exists(word_of(a, b, i))) begin
                d[i] = model[word_of(a, b, i)];
                known[i] = 1'b1;
            end
        end
    endtask

    // ---------------- transaction tasks (called at a negedge) ----------------
    // Presents a request, waits (bounded) for ready, returns at the first
    // negedge after the accepting posedge with req_valid dropped.
    task automatic issue(input bit wr, input bit b, input logic [31:0] a);
        int t;
        t = 0;
        req_write = wr;
        req_burst = b;
        req_addr  = a;
        req_valid = 1'b1;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("issue_ready", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_write = 1'(($urandom));
        req_burst = 1'(($urandom));
    endtask

    // Checks a read from negedge #1 after accept; first beat on negedge #LAT.
    task automatic expect_read(input logic [3:0][31:0] d, input int n, input logic [3:0] known);
        for (int k = 1; k <= LAT + n; k++) begin
            if (k > 1) @(negedge clk);
            wdata_valid = 1'(($urandom));
            wdata       = $urandom;
            check("rd_wdata_ready", wdata_ready, 0);
            if (k < LAT + n) begin
                check("rd_busy", busy, 1);
                check("rd_req_ready", req_ready, 0);
                check("rd_valid", rdata_valid, (k >= LAT));
                if (k >= LAT) begin
                    check("rd_last", rdata_last, (k == LAT + n - 1));
                    if (known[k - LAT]) check("rd_data", rdata, d[k - LAT]);
                end else begin
                    check("rd_data_idle", rdata, 0);
                end
            end else begin
                check("rd_valid_end", rdata_valid, 0);
                check("rd_ready_end", req_ready, 1);
                check("rd_busy_end", busy, 0);
            end
        end
        wdata_valid = 1'b0;
    endtask

    task automatic write_beats(input logic [3:0][31:0] d, input int n,
                               input int gap_at, input int gap_len);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    wdata_valid = 1'b0;
                    wdata       = $urandom;
                    check("wr_ready_gap", wdata_ready, 1);
                    check("wr_done_gap", wr_done, 0);
                    @(negedge clk);
                end
            end
            wdata_valid = 1'b1;
            wdata       = d[i];
            check("wr_ready", wdata_ready, 1);
            check("wr_done_early", wr_done, 0);
            @(negedge clk);
        end
        wdata_valid = 1'b0;
        check("wr_done", wr_done, 1);
        check("wr_done_req_ready", req_ready, 0);
        @(negedge clk);
        check("wr_done_clear", wr_done, 0);
        check("wr_ready_after", req_ready, 1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit              wr;
        bit              burst;
        logic [31:0]     addr;
        logic [3:0][31:0] d;     // write data, or expected read data
        int              gap_at;
        int              gap_len;
    } vec_t;

    vec_t tbl [10];
    int   n_tbl = 0;

    task automatic add_vec(input bit wr, input bit b, input logic [31:0] a,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3,
                           input int gap_at, input int gap_len);
        tbl[n_tbl].wr      = wr;
        tbl[n_tbl].burst   = b;
        tbl[n_tbl].addr    = a;
        tbl[n_tbl].d       = {d3, d2, d1, d0};
        tbl[n_tbl].gap_at  = gap_at;
        tbl[n_tbl].gap_len = gap_len;
        n_tbl++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [3:0][31:0] d;
        logic [3:0]       known;
        bit               wr, b;
        logic [31:0]      a;
        int               n;

        rst = 1'b1;
        req_valid = 0; req_write = 0; req_burst = 0; req_addr = '0;
        wdata_valid = 0; wdata = '0;
        req_valid1 = 0; req_write1 = 0; req_burst1 = 0; req_addr1 = '0;
        wdata_valid1 = 0; wdata1 = '0;

        add_vec(1, 0, 32'h0000_0040, 32'hDEADBEEF, 0, 0, 0, -1, 0);
        add_vec(0, 0, 32'h0000_0040, 32'hDEADBEEF, 0, 0, 0, -1, 0);
        add_vec(1, 1, 32'h0000_0108, 32'h11, 32'h22, 32'h33, 32'h44, 2, 2);
        add_vec(0, 1, 32'h0000_0100, 32'h11, 32'h22, 32'h33, 32'h44, -1, 0);
        add_vec(0, 0, 32'h0000_010C, 32'h44, 0, 0, 0, -1, 0);
        add_vec(0, 0, 32'h0000_0108, 32'h33, 0, 0, 0, -1, 0);
        add_vec(0, 1, 32'h0000_010C, 32'h11, 32'h22, 32'h33, 32'h44, -1, 0);
        add_vec(0, 0, 32'h0002_0040, 32'hDEADBEEF, 0, 0, 0, -1, 0);
        add_vec(1, 0, 32'h0002_0044, 32'hCAFEF00D, 0, 0, 0, -1, 0);
        add_vec(0, 0, 32'h0000_0044, 32'hCAFEF00D, 0, 0, 0, -1, 0);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rvalid", rdata_valid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rlast", rdata_last, 0);
        check("rst_wr_done", wr_done, 0);
        check("rst_wready", wdata_ready, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        for (int v = 0; v < n_tbl; v++) begin
            issue(tbl[v].wr, tbl[v].burst, tbl[v].addr);
            n = tbl[v].burst ? LW : 1;
            if (tbl[v].wr) begin
                write_beats(tbl[v].d, n, tbl[v].gap_at, tbl[v].gap_len);
                model_write(tbl[v].addr, tbl[v].burst, tbl[v].d, n);
            end else begin
                expect_read(tbl[v].d, n, 4'hF);
            end
        end

        // Request held while busy: burst read, next request waits for IDLE
        issue(0, 1, 32'h0000_0100);
        req_write = 0; req_burst = 0; req_addr = 32'h0002_0040; req_valid = 1'b1;
        expect_read({32'h44, 32'h33, 32'h22, 32'h11}, LW, 4'hF);
        issue(0, 0, 32'h0002_0040);
        expect_read({96'h0, 32'hDEADBEEF}, 1, 4'h1);

        // Async reset in the middle of a read
        issue(0, 1, 32'h0000_0100);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ready", req_ready, 1);
        check("arst_rvalid", rdata_valid, 0);
        check("arst_rdata", rdata, 0);
        check("arst_rlast", rdata_last, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset after two of four write beats
        issue(1, 1, 32'h0000_0100);
        wdata_valid = 1'b1; wdata = 32'hAA;
        @(negedge clk);
        wdata = 32'hBB;
        @(negedge clk);
        wdata_valid = 1'b0;
        check("mid_wr_done", wr_done, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_wr_done", wr_done, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wready", wdata_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_no_pulse", wr_done, 0);
        @(negedge clk);
        model[word_of(32'h100, 1, 0)] = 32'hAA;
        model[word_of(32'h100, 1, 1)] = 32'hBB;
        issue(0, 1, 32'h0000_0100);
        expect_read({32'h44, 32'h33, 32'hBB, 32'hAA}, LW, 4'hF);

        // Random traffic against the model
        for (int r = 0; r < 60; r++) begin
            wr = 1'(($urandom));
            b  = 1'(($urandom));
            a  = ($urandom & 32'hFFFE_0000) | (32'($urandom_range(0, 127)) << 2)
                 | 32'($urandom_range(0, 3));
            n  = b ? LW : 1;
            issue(wr, b, a);
            if (wr) begin
                for (int i = 0; i < LW; i++) d[i] = $urandom;
                write_beats(d, n, $urandom_range(0, n), $urandom_range(0, 2));
                model_write(a, b, d, n);
            end else begin
                model_read(a, b, n, d, known);
                expect_read(d, n, known);
            end
        end

        // LATENCY=1 build: write then read, first beat one cycle after accept
        req_valid1 = 1'b1; req_write1 = 1'b1; req_burst1 = 1'b0; req_addr1 = 32'h80;
        check("l1_ready_idle", req_ready1, 1);
        @(negedge clk);
        req_valid1 = 1'b0;
        wdata_valid1 = 1'b1; wdata1 = 32'h1234_5678;
        check("l1_wready", wdata_ready1, 1);
        @(negedge clk);
        wdata_valid1 = 1'b0;
        check("l1_wr_done", wr_done1, 1);
        @(negedge clk);
        check("l1_ready_after_wr", req_ready1, 1);
        req_valid1 = 1'b1; req_write1 = 1'b0; req_addr1 = 32'h80;
        check("l1_rvalid_before", rdata_valid1, 0);
        @(negedge clk);
        req_valid1 = 1'b0;
        check("l1_rvalid_t1", rdata_valid1, 1);
        check("l1_rdata", rdata1, 32'h1234_5678);
        check("l1_rlast", rdata_last1, 1);
        @(negedge clk);
        check("l1_rvalid_end", rdata_valid1, 0);
        check("l1_ready_end", req_ready1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_main_mem_responder
`default_nettype wire
